// File: rtl/uart_mmio_pkg.sv
// +---------------------------------------------------------------------+
// | uart_mmio_pkg : register map, status bits and drain FSM encodings    |
// | rev 1.0                                                              |
// +---------------------------------------------------------------------+
`default_nettype none

package uart_mmio_pkg;

  typedef logic [1:0] reg_idx_t;

  localparam reg_idx_t REG_TXDATA = 2'd0;
  localparam reg_idx_t REG_RXDATA = 2'd1;
  localparam reg_idx_t REG_STATUS = 2'd2;
  localparam reg_idx_t REG_CTRL   = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_DROP    = 2;
  localparam int STAT_CNT_LSB = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] RX_NONE = 8'hFF;

  // A 256-entry FIFO can hold 256, which does not fit the 8-bit count field.
  function automatic logic [7:0] sat_count(input logic [8:0] c);
    return (c > 9'd255) ? 8'hFF : c[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +---------------------------------------------------------------------+
// | uart_tx_fifo : synchronous byte FIFO with occupancy count            |
// | rev 1.0                                                              |
// +---------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_mmio.sv
// +---------------------------------------------------------------------+
// | uart_mmio : memory-mapped console UART (TX FIFO + drain, RX polling) |
// | rev 1.0                                                              |
// +---------------------------------------------------------------------+
`default_nettype none

module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [63:0] BASE   = 64'h1000_0000,
  parameter int          DEPTH  = 16,
  parameter int          TX_GAP = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        uart_out_valid,
  output logic [7:0]  uart_out_ch,
  output logic        uart_in_valid,
  input  logic [7:0]  uart_in_ch
);

  localparam logic [7:0] GAP_LOAD = (TX_GAP > 0) ? 8'(TX_GAP - 1) : 8'd0;

  logic                   hit;
  reg_idx_t               idx;
  logic                   is_read;
  logic                   push_req;
  logic                   ctrl_clear;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [7:0]             fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   tx_drop;
  logic [1:0]             state;
  logic [7:0]             gap_cnt;
  logic [63:0]            status_word;
  logic [63:0]            rd_next;
  logic                   unused_ok;

  assign hit        = en && (addr[63:5] == BASE[63:5]);
  assign idx        = addr[4:3];
  assign is_read    = en && (we == 8'h00);
  assign push_req   = hit && (idx == REG_TXDATA) && we[0];
  assign ctrl_clear = hit && (idx == REG_CTRL) && we[0] && wdata[0];

  assign uart_in_valid  = !reset && hit && (we == 8'h00) && (idx == REG_RXDATA);
  assign uart_out_valid = !reset && (state == ST_SEND);
  assign uart_out_ch    = uart_out_valid ? fifo_dout : 8'h00;

  assign unused_ok = ^{addr[2:0], wdata[63:8]};

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (state == ST_SEND),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty && (state == ST_IDLE);
    status_word[STAT_DROP]  = tx_drop;
    status_word[STAT_CNT_LSB +: 8] = sat_count(9'(fifo_count));
  end

  always_comb begin
    rd_next = '0;
    if (hit) begin
      case (idx)
        REG_RXDATA: rd_next = (uart_in_ch == RX_NONE) ? '1 : {56'b0, uart_in_ch};
        REG_STATUS: rd_next = status_word;
        default:    rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (is_read) begin
      rdata <= rd_next;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_drop <= 1'b0;
    end else if (push_req && fifo_full) begin
      tx_drop <= 1'b1;
    end else if (ctrl_clear) begin
      tx_drop <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      gap_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_SEND;
        end
        ST_SEND: begin
          if (TX_GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) state <= ST_IDLE;
          else                 gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
